demux_dispatch_ctrl: RTL and testbench

- Sequencing controller that sits in front of the 1-to-4 demultiplexer datapath.
- Accepts one input stream over a valid/ready handshake and holds each item in a single-entry buffer.
- Steers each item to exactly one of four output channels, either round-robin or by an explicit destination field.
- Keeps a per-channel saturating count of delivered items for status and debug.

---
 rtl/demux_dispatch_ctrl.sv | 120 ++++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl
// Front-end sequencer for the 1-to-4 demultiplexer datapath. It holds one item
// in a single-entry buffer and steers it to one of four channels, either in
// round-robin order or by an explicit destination field. It also keeps a
// saturating delivery count for each channel.
module demux_dispatch_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [1:0]           in_dest,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [1:0]           out_sel,
    output logic                 busy,
    output logic [4*CNT_W-1:0]   sent_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q;
    logic [1:0]         rrPtr_q;
    logic [1:0]         outSel_q;
    logic [DATA_W-1:0]  outData_q;
    logic [CNT_W-1:0]   count_q [4];
    logic [CNT_W-1:0]   count_d [4];

    logic               isFull;
    logic               fire;
    logic               capture;

    assign isFull  = (state_q == FULL);

    // Only the bound channel's ready matters; other channels never cause a
    // delivery.
    assign fire    = isFull & out_ready[outSel_q];

    // Refill in the same cycle as a delivery keeps throughput at one item per
    // cycle. This makes out_ready -> in_ready a combinational path.
    assign in_ready = ~rst & (~isFull | fire);
    assign capture  = in_valid & in_ready;

    assign busy     = isFull;
    assign out_sel  = outSel_q;
    assign out_data = outData_q;

    // One-hot offer on the bound channel while the buffer holds an item.
    always_comb begin
        out_valid = 4'b0000;
        if (isFull) begin
            out_valid[outSel_q] = 1'b1;
        end
    end

    // Buffer state machine: capture loads a new item and its channel binding;
    // a delivery with no refill frees the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            rrPtr_q   <= 2'd0;
            outSel_q  <= 2'd0;
            outData_q <= '0;
        end else begin
            if (capture) begin
                state_q   <= FULL;
                outData_q <= in_data;
                outSel_q  <= mode ? in_dest : rrPtr_q;
                if (!mode) begin
                    rrPtr_q <= rrPtr_q + 2'd1;
                end
            end else if (fire) begin
                state_q <= EMPTY;
            end
        end
    end

    // Next-count logic: the delivering channel steps by one and sticks at its
    // maximum instead of wrapping.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            count_d[k] = count_q[k];
            if (fire && (outSel_q == 2'(k)) && (count_q[k] != CNT_MAX)) begin
                count_d[k] = count_q[k] + 1'b1;
            end
        end
    end

    // Per-channel delivery counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                count_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                count_q[k] <= count_d[k];
            end
        end
    end

    // Pack counters so channel k sits at bits [k*CNT_W +: CNT_W].
    always_comb begin
        sent_count = '0;
        for (int k = 0; k < 4; k++) begin
            sent_count[k*CNT_W +: CNT_W] = count_q[k];
        end
    end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb_demux_dispatch_ctrl
// Directed bench for demux_dispatch_ctrl. Built with CNT_W=2 so counter
// saturation is reachable in a few deliveries; channel k count sits at bits
// [2k+1:2k] of sent_count.
module tb_demux_dispatch_ctrl;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;

    logic                clk;
    logic                rst;
    logic                mode;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic [1:0]          in_dest;
    logic [3:0]          out_valid;
    logic [3:0]          out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_sel;
    logic                busy;
    logic [4*CNT_W-1:0]  sent_count;

    int checkCount;
    int passCount;

    demux_dispatch_ctrl #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .busy       (busy),
        .sent_count (sent_count)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 unit after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change before sampling.
    task automatic settle();
        #1;
    endtask

    // Drive the input side of the handshake.
    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic m, input logic [1:0] dst,
                                 input logic [3:0] rdy);
        in_valid  = v;
        in_data   = d;
        mode      = m;
        in_dest   = dst;
        out_ready = rdy;
    endtask

    // Reset with quiet inputs, check the held-in-reset outputs, then release.
    task automatic doReset(input string tag);
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);
        rst = 1'b1;
        tick();
        tick();
        checkOutput({tag, "_rst_valid"}, 32'(out_valid), 32'h0);
        checkOutput({tag, "_rst_busy"},  32'(busy),      32'h0);
        checkOutput({tag, "_rst_ready"}, 32'(in_ready),  32'h0);
        rst = 1'b0;
        settle();
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);

        // ---- Round-robin, five back-to-back items, all channels ready ----
        doReset("rr");
        checkOutput("rr_rst_data",  32'(out_data),   32'h0);
        checkOutput("rr_rst_sel",   32'(out_sel),    32'h0);
        checkOutput("rr_rst_count", 32'(sent_count), 32'h0);
        checkOutput("rr_ready_idle", 32'(in_ready),  32'h1);
        applyStimulus(1'b1, 8'h11, 1'b0, 2'd0, 4'b1111);
        begin
            logic [7:0] expData [5];
            logic [3:0] expValid [5];
            expData  = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
            expValid = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            for (int i = 0; i < 5; i++) begin
                tick();
                if (i < 4) begin
                    in_data = expData[i+1];
                end else begin
                    in_valid = 1'b0;
                end
                settle();
                checkOutput($sformatf("rr_valid%0d", i), 32'(out_valid), 32'(expValid[i]));
                checkOutput($sformatf("rr_data%0d", i),  32'(out_data),  32'(expData[i]));
                checkOutput($sformatf("rr_ready%0d", i), 32'(in_ready),  32'h1);
            end
        end
        tick();
        settle();
        checkOutput("rr_busy_end",  32'(busy),       32'h0);
        checkOutput("rr_count_end", 32'(sent_count), 32'h56);

        // ---- Explicit destination, stalled channel 2 ----
        doReset("dst");
        applyStimulus(1'b1, 8'hA0, 1'b1, 2'd2, 4'b1011);
        tick();
        in_data = 8'hA1;
        settle();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("dst_stall_valid%0d", i), 32'(out_valid), 32'h4);
            checkOutput($sformatf("dst_stall_data%0d", i),  32'(out_data),  32'hA0);
            checkOutput($sformatf("dst_stall_ready%0d", i), 32'(in_ready),  32'h0);
            if (i < 2) begin
                tick();
                settle();
            end
        end
        tick();
        out_ready = 4'b1111;
        settle();
        checkOutput("dst_fire_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        settle();
        checkOutput("dst_second_data",  32'(out_data),  32'hA1);
        checkOutput("dst_second_valid", 32'(out_valid), 32'h4);
        checkOutput("dst_count_mid",    32'(sent_count), 32'h10);
        tick();
        settle();
        checkOutput("dst_count_end", 32'(sent_count), 32'h20);
        // rr pointer must not have moved during explicit dispatch.
        applyStimulus(1'b1, 8'h33, 1'b0, 2'd3, 4'b0000);
        tick();
        in_valid = 1'b0;
        settle();
        checkOutput("dst_rr_unmoved", 32'(out_sel), 32'h0);

        // ---- Non-selected ready is ignored ----
        doReset("ign");
        applyStimulus(1'b1, 8'h5C, 1'b1, 2'd1, 4'b1101);
        tick();
        in_valid = 1'b0;
        settle();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("ign_valid%0d", i), 32'(out_valid),  32'h2);
            checkOutput($sformatf("ign_count%0d", i), 32'(sent_count), 32'h0);
            tick();
            settle();
        end
        out_ready = 4'b1111;
        tick();
        settle();
        checkOutput("ign_count_fire", 32'(sent_count), 32'h04);
        checkOutput("ign_busy_fire",  32'(busy),       32'h0);

        // ---- Counter saturation on channel 3 ----
        doReset("sat");
        applyStimulus(1'b1, 8'h01, 1'b1, 2'd3, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) begin
                in_valid = 1'b0;
            end
        end
        tick();
        settle();
        checkOutput("sat_count", 32'(sent_count), 32'hC0);

        // ---- Asynchronous reset while holding an item ----
        doReset("arst");
        applyStimulus(1'b1, 8'h42, 1'b1, 2'd1, 4'b1111);
        tick();
        in_dest   = 2'd2;
        in_data   = 8'h43;
        out_ready = 4'b0010;
        tick();
        in_valid = 1'b0;
        settle();
        checkOutput("arst_pre_valid", 32'(out_valid),  32'h4);
        checkOutput("arst_pre_count", 32'(sent_count), 32'h04);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(out_valid),  32'h0);
        checkOutput("arst_busy",  32'(busy),       32'h0);
        checkOutput("arst_count", 32'(sent_count), 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 8'h44, 1'b0, 2'd3, 4'b0000);
        tick();
        in_valid = 1'b0;
        settle();
        checkOutput("arst_next_valid", 32'(out_valid), 32'h1);
        checkOutput("arst_next_data",  32'(out_data),  32'h44);

        // ---- Mode change while holding does not retarget ----
        doReset("mchg");
        applyStimulus(1'b1, 8'h60, 1'b0, 2'd0, 4'b0000);
        tick();
        in_data   = 8'h61;
        out_ready = 4'b0001;
        tick();
        applyStimulus(1'b0, 8'h61, 1'b1, 2'd3, 4'b0000);
        settle();
        checkOutput("mchg_hold_sel",   32'(out_sel),   32'h1);
        checkOutput("mchg_hold_valid", 32'(out_valid), 32'h2);
        tick();
        applyStimulus(1'b1, 8'h77, 1'b1, 2'd3, 4'b1111);
        settle();
        checkOutput("mchg_fire_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        settle();
        checkOutput("mchg_new_sel",   32'(out_sel),    32'h3);
        checkOutput("mchg_new_valid", 32'(out_valid),  32'h8);
        checkOutput("mchg_new_data",  32'(out_data),   32'h77);
        checkOutput("mchg_count",     32'(sent_count), 32'h05);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
